// File: rtl/weight_bank.sv
// weight_bank: a small bank of NUM_W signed weights.
// An init pass loads INIT_VAL into every weight in one cycle.
// An update pass accepts one delta per weight, in index order, through a
// valid/ready handshake.
// Compile-time option WEIGHT_BANK_SAT_EN: when defined, updates that overflow
// clamp to the signed range and set sat_flag. When undefined, updates wrap in
// two's complement and sat_flag stays 0.
//
// state  | meaning
// IDLE   | waiting for init_start / upd_start
// UPD    | accepting deltas, one per weight, index 0 .. NUM_W-1
// DONE   | single-cycle completion pulse, then back to IDLE
module weight_bank #(
    parameter int                        NUM_W    = 4,
    parameter int                        DATA_W   = 16,
    parameter int                        FRAC_W   = 10,
    parameter logic [NUM_W*DATA_W-1:0]   INIT_VAL = {NUM_W{16'h0533}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init_start,
    input  logic                         upd_start,
    input  logic [DATA_W-1:0]            dw_in,
    input  logic                         dw_valid,
    output logic                         dw_ready,
    output logic [NUM_W*DATA_W-1:0]      w_flat,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag
);

    localparam int IDX_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_W - 1);

    // The fixed-point format is carried for documentation only; the
    // arithmetic does not depend on it, but it must fit inside a word.
    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_frac_check
        $error("weight_bank: FRAC_W must lie in [0, DATA_W-1]");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  w_q [NUM_W];
    logic [DATA_W-1:0]  w_d [NUM_W];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  cur_w;
    logic [DATA_W-1:0]  upd_val;
    logic               xfer;

    assign cur_w = w_q[idx_q];
    assign xfer  = (state_q == S_UPD) && dw_valid;

`ifdef WEIGHT_BANK_SAT_EN
    localparam logic [DATA_W-1:0] W_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0]    sum_wide;
    logic               ovf;
    logic               sat_q, sat_d;

    // One extra bit of headroom. Overflow shows up as a disagreement
    // between the top two bits of the sum, and the top bit gives the
    // direction of the clamp.
    assign sum_wide = {cur_w[DATA_W-1], cur_w} + {dw_in[DATA_W-1], dw_in};
    assign ovf      = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
    assign upd_val  = !ovf ? sum_wide[DATA_W-1:0]
                           : (sum_wide[DATA_W] ? W_MIN : W_MAX);
    assign sat_flag = sat_q;
`else
    // Wrap mode: the low DATA_W bits of the widened sum equal a plain
    // DATA_W-bit add.
    assign upd_val  = cur_w + dw_in;
    assign sat_flag = 1'b0;
`endif

    for (genvar k = 0; k < NUM_W; k++) begin : g_flat
        assign w_flat[k*DATA_W +: DATA_W] = w_q[k];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (init_start)     state_d = S_DONE;
                else if (upd_start) state_d = S_UPD;
            end
            S_UPD: begin
                if (dw_valid && idx_q == LAST_IDX) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        dw_ready = (state_q == S_UPD);
    end

    // Datapath next values: init load, pass start, per-transfer update
    always_comb begin
        w_d   = w_q;
        idx_d = idx_q;
`ifdef WEIGHT_BANK_SAT_EN
        sat_d = sat_q;
`endif
        if (state_q == S_IDLE) begin
            if (init_start) begin
                for (int k = 0; k < NUM_W; k++) begin
                    w_d[k] = INIT_VAL[k*DATA_W +: DATA_W];
                end
                idx_d = '0;
`ifdef WEIGHT_BANK_SAT_EN
                sat_d = 1'b0;
`endif
            end else if (upd_start) begin
                idx_d = '0;
`ifdef WEIGHT_BANK_SAT_EN
                sat_d = 1'b0;
`endif
            end
        end else if (xfer) begin
            w_d[idx_q] = upd_val;
            idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
`ifdef WEIGHT_BANK_SAT_EN
            sat_d      = sat_q | ovf;
`endif
        end
    end

    // Datapath registers; reset clears every weight and the index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_W; k++) begin
                w_q[k] <= '0;
            end
            idx_q <= '0;
`ifdef WEIGHT_BANK_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            w_q   <= w_d;
            idx_q <= idx_d;
`ifdef WEIGHT_BANK_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank with the default parameters
// (NUM_W=4, DATA_W=16). Expected saturation behaviour follows
// WEIGHT_BANK_SAT_EN.
module tb_weight_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_start = 1'b0;
    logic        upd_start = 1'b0;
    logic [15:0] dw_in = 16'h0000;
    logic        dw_valid = 1'b0;
    logic        dw_ready;
    logic [63:0] w_flat;
    logic        busy;
    logic        done;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;

    weight_bank dut (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .upd_start  (upd_start),
        .dw_in      (dw_in),
        .dw_valid   (dw_valid),
        .dw_ready   (dw_ready),
        .w_flat     (w_flat),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        init;
        logic        upd;
        logic        valid;
        logic [15:0] dw;
        logic [63:0] exp_w;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_ready;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        d = '{d0, d1, d2, d3};
        upd_start = 1'b1;
        step();
        upd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dw_valid = 1'b1;
            dw_in    = d[i];
            step();
        end
        dw_valid = 1'b0;
        dw_in    = 16'h0000;
        step();
    endtask

    localparam logic [63:0] W_INIT = {4{16'h0533}};
    localparam logic [63:0] W_A1 = {16'h0533, 16'h0533, 16'h0533, 16'h0633};
    localparam logic [63:0] W_A2 = {16'h0533, 16'h0533, 16'h0433, 16'h0633};
    localparam logic [63:0] W_A4 = {16'h0933, 16'h0533, 16'h0433, 16'h0633};
    localparam logic [63:0] W_B1 = {16'h0933, 16'h0533, 16'h0433, 16'h0643};
    localparam logic [63:0] W_B2 = {16'h0933, 16'h0533, 16'h0443, 16'h0643};
    localparam logic [63:0] W_B3 = {16'h0933, 16'h0543, 16'h0443, 16'h0643};
    localparam logic [63:0] W_B4 = {16'h0943, 16'h0543, 16'h0443, 16'h0643};

`ifdef WEIGHT_BANK_SAT_EN
    localparam logic [15:0] EXP_W0_OVF  = 16'h7FFF;
    localparam logic [15:0] EXP_W1_OVF  = 16'h8000;
    localparam logic        EXP_SAT_OVF = 1'b1;
`else
    localparam logic [15:0] EXP_W0_OVF  = 16'h8100;
    localparam logic [15:0] EXP_W1_OVF  = 16'h0533;
    localparam logic        EXP_SAT_OVF = 1'b0;
`endif

    initial begin
        //         init  upd   valid dw        exp_w   busy  done  ready
        vec[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, W_INIT, 1'b1, 1'b0, 1'b1};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 16'h0100, W_A1,   1'b1, 1'b0, 1'b1};
        vec[2]  = '{1'b0, 1'b0, 1'b1, 16'hFF00, W_A2,   1'b1, 1'b0, 1'b1};
        vec[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, W_A2,   1'b1, 1'b0, 1'b1};
        vec[4]  = '{1'b0, 1'b0, 1'b1, 16'h0400, W_A4,   1'b1, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, W_A4,   1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, W_A4,   1'b1, 1'b0, 1'b1};
        vec[7]  = '{1'b0, 1'b0, 1'b1, 16'h0010, W_B1,   1'b1, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 16'h7FFF, W_B1,   1'b1, 1'b0, 1'b1};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 16'h7FFF, W_B1,   1'b1, 1'b0, 1'b1};
        vec[10] = '{1'b0, 1'b0, 1'b1, 16'h0010, W_B2,   1'b1, 1'b0, 1'b1};
        vec[11] = '{1'b0, 1'b0, 1'b1, 16'h0010, W_B3,   1'b1, 1'b0, 1'b1};
        vec[12] = '{1'b1, 1'b1, 1'b0, 16'h7FFF, W_B3,   1'b1, 1'b0, 1'b1};
        vec[13] = '{1'b0, 1'b0, 1'b1, 16'h0010, W_B4,   1'b1, 1'b1, 1'b0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, W_B4,   1'b0, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_w_flat", w_flat, 64'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", dw_ready, 1'b0);
        chk("rst_sat", sat_flag, 1'b0);

        // Init is accepted on the first edge after reset release
        @(posedge clk);
        #1;
        reset      = 1'b1;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        chk("init_w_flat", w_flat, W_INIT);
        chk("init_done", done, 1'b1);
        chk("init_busy", busy, 1'b1);
        step();
        chk("init_done_end", done, 1'b0);
        chk("init_busy_end", busy, 1'b0);

        // Full pass, then a pass with stalls and ignored start pulses
        for (int i = 0; i < 15; i++) begin
            init_start = vec[i].init;
            upd_start  = vec[i].upd;
            dw_valid   = vec[i].valid;
            dw_in      = vec[i].dw;
            step();
            chk($sformatf("vec%0d_w_flat", i), w_flat, vec[i].exp_w);
            chk($sformatf("vec%0d_busy", i), busy, vec[i].exp_busy);
            chk($sformatf("vec%0d_done", i), done, vec[i].exp_done);
            chk($sformatf("vec%0d_ready", i), dw_ready, vec[i].exp_ready);
            chk($sformatf("vec%0d_sat", i), sat_flag, 1'b0);
        end
        init_start = 1'b0;
        upd_start  = 1'b0;
        dw_valid   = 1'b0;
        dw_in      = 16'h0000;

        // Overflow: bring w0 to 0x7F00 and w1 to 0x8533, then push both past the range
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        step();
        run_pass(16'h79CD, 16'h8000, 16'h0000, 16'h0000);
        chk("pre_ovf_w_flat", w_flat, {16'h0533, 16'h0533, 16'h8533, 16'h7F00});
        chk("pre_ovf_sat", sat_flag, 1'b0);
        upd_start = 1'b1;
        step();
        upd_start = 1'b0;
        dw_valid  = 1'b1;
        dw_in     = 16'h0200;
        step();
        chk("ovf_pos_w0", w_flat[15:0], EXP_W0_OVF);
        chk("ovf_pos_sat", sat_flag, EXP_SAT_OVF);
        dw_in = 16'h8000;
        step();
        chk("ovf_neg_w1", w_flat[31:16], EXP_W1_OVF);
        dw_in = 16'h0000;
        step();
        step();
        chk("ovf_done", done, 1'b1);
        dw_valid = 1'b0;
        step();
        chk("ovf_sat_held", sat_flag, EXP_SAT_OVF);
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        chk("ovf_sat_cleared", sat_flag, 1'b0);
        chk("reinit_w_flat", w_flat, W_INIT);
        step();

        // Asynchronous reset after two transfers of a pass
        upd_start = 1'b1;
        step();
        upd_start = 1'b0;
        dw_valid  = 1'b1;
        dw_in     = 16'h0100;
        step();
        step();
        chk("abort_pre_w_flat", w_flat, {16'h0533, 16'h0533, 16'h0633, 16'h0633});
        dw_valid = 1'b0;
        reset    = 1'b0;
        #2;
        chk("abort_w_flat", w_flat, 64'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", dw_ready, 1'b0);
        chk("abort_sat", sat_flag, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("abort_hold%0d_done", i), done, 1'b0);
            chk($sformatf("abort_hold%0d_w_flat", i), w_flat, 64'h0);
        end
        reset      = 1'b1;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        chk("restore_w_flat", w_flat, W_INIT);
        chk("restore_done", done, 1'b1);
        step();
        chk("restore_done_end", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
